// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Stall/flush controller for the 5-stage pipeline. It merges three hazard
//   sources with the priority memory wait > load-use > taken branch:
//   - data-memory wait handshake
//   - load-use detection
//   - taken-branch flush resolved in ID
//   Control outputs are combinational so they act in the same cycle. The
//   state, the wait counter, the performance counters and the timeout flag
//   are registered.
//
// Ports
//   clk_i           rising-edge clock
//   rst_i           asynchronous active-low reset
//   IDEX_MemRead_i  instruction in EX is a load
//   IDEX_Rd_i       destination register of the instruction in EX
//   IFID_Rs1_i      rs1 of the instruction in ID
//   IFID_Rs2_i      rs2 of the instruction in ID
//   IFID_UseRs2_i   instruction in ID reads rs2
//   Branch_taken_i  branch in ID resolved taken
//   mem_req_i       MEM stage issues a data access (sampled in RUN only)
//   mem_ack_i       data memory completes the access
//   PCWrite_o       PC update enable
//   IFID_Stall_o    hold the IF/ID register
//   IFID_Flush_o    zero the IF/ID register
//   IDEX_Bubble_o   insert a NOP into ID/EX
//   Freeze_o        hold ID/EX, EX/MEM and MEM/WB
//   stall_cnt_o     saturating count of cycles with PCWrite_o=0
//   flush_cnt_o     saturating count of cycles with IFID_Flush_o=1
//   err_timeout_o   sticky memory-timeout flag
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | no data access outstanding; mem_req_i is sampled here
// MEM_WAIT | data access outstanding; pipeline frozen until mem_ack_i

module pipeline_hazard_ctrl #(
   parameter int CNT_W    = 16,
   parameter int MAX_WAIT = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             IDEX_MemRead_i,
   input  logic [4:0]       IDEX_Rd_i,
   input  logic [4:0]       IFID_Rs1_i,
   input  logic [4:0]       IFID_Rs2_i,
   input  logic             IFID_UseRs2_i,
   input  logic             Branch_taken_i,
   input  logic             mem_req_i,
   input  logic             mem_ack_i,
   output logic             PCWrite_o,
   output logic             IFID_Stall_o,
   output logic             IFID_Flush_o,
   output logic             IDEX_Bubble_o,
   output logic             Freeze_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic             err_timeout_o
);

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   state_t     state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       hz, mw;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q       <= RUN;
         wait_cnt_q    <= 8'd0;
         stall_cnt_o   <= '0;
         flush_cnt_o   <= '0;
         err_timeout_o <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         if (!PCWrite_o && (stall_cnt_o != {CNT_W{1'b1}}))
            stall_cnt_o <= stall_cnt_o + 1'b1;
         if (IFID_Flush_o && (flush_cnt_o != {CNT_W{1'b1}}))
            flush_cnt_o <= flush_cnt_o + 1'b1;
         // evaluated on the registered count, so an ack in the cycle the
         // count sits at MAX_WAIT still raises the flag
         if ((state_q == MEM_WAIT) && (wait_cnt_q == MAX_WAIT_C))
            err_timeout_o <= 1'b1;
      end
   end

   always_comb begin
      hz = IDEX_MemRead_i && (IDEX_Rd_i != 5'd0) &&
           ((IDEX_Rd_i == IFID_Rs1_i) ||
            (IFID_UseRs2_i && (IDEX_Rd_i == IFID_Rs2_i)));
      mw = ((state_q == RUN) && mem_req_i && !mem_ack_i) ||
           ((state_q == MEM_WAIT) && !mem_ack_i);
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         RUN: begin
            wait_cnt_d = 8'd0;
            if (mem_req_i && !mem_ack_i) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = 8'd1;
            end
         end
         MEM_WAIT: begin
            if (mem_ack_i) begin
               state_d = RUN;
            end else if (wait_cnt_q != 8'hFF) begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = 8'd0;
         end
      endcase
   end

   always_comb begin
      PCWrite_o     = 1'b1;
      IFID_Stall_o  = 1'b0;
      IFID_Flush_o  = 1'b0;
      IDEX_Bubble_o = 1'b0;
      Freeze_o      = 1'b0;
      if (mw) begin
         PCWrite_o    = 1'b0;
         IFID_Stall_o = 1'b1;
         Freeze_o     = 1'b1;
      end else if (hz) begin
         // the branch in ID is dropped here and seen again after the bubble
         PCWrite_o     = 1'b0;
         IFID_Stall_o  = 1'b1;
         IDEX_Bubble_o = 1'b1;
      end else if (Branch_taken_i) begin
         IFID_Flush_o = 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

   localparam int CNT_W    = 4;
   localparam int MAX_WAIT = 4;

   // {PCWrite, IFID_Stall, IFID_Flush, IDEX_Bubble, Freeze}
   localparam logic [4:0] C_IDLE = 5'b10000;
   localparam logic [4:0] C_HZ   = 5'b01010;
   localparam logic [4:0] C_FL   = 5'b10100;
   localparam logic [4:0] C_MW   = 5'b01001;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             IDEX_MemRead_i;
   logic [4:0]       IDEX_Rd_i, IFID_Rs1_i, IFID_Rs2_i;
   logic             IFID_UseRs2_i, Branch_taken_i, mem_req_i, mem_ack_i;
   logic             PCWrite_o, IFID_Stall_o, IFID_Flush_o, IDEX_Bubble_o, Freeze_o;
   logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
   logic             err_timeout_o;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       rst, mr;
      logic [4:0] rd, rs1, rs2;
      logic       u2, br, req, ack;
      logic [4:0] ctrl;
      logic       err;
   } vec_t;

   typedef struct {
      int               idx;
      logic [4:0]       ctrl;
      logic [CNT_W-1:0] stall, flush;
      logic             err;
   } exp_t;

   vec_t vq[$];
   exp_t sb[$];
   exp_t mon_e;
   exp_t drv_e;
   logic [4:0] act_ctrl;
   logic [CNT_W-1:0] mdl_stall, mdl_flush;

   pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .IDEX_MemRead_i (IDEX_MemRead_i),
      .IDEX_Rd_i      (IDEX_Rd_i),
      .IFID_Rs1_i     (IFID_Rs1_i),
      .IFID_Rs2_i     (IFID_Rs2_i),
      .IFID_UseRs2_i  (IFID_UseRs2_i),
      .Branch_taken_i (Branch_taken_i),
      .mem_req_i      (mem_req_i),
      .mem_ack_i      (mem_ack_i),
      .PCWrite_o      (PCWrite_o),
      .IFID_Stall_o   (IFID_Stall_o),
      .IFID_Flush_o   (IFID_Flush_o),
      .IDEX_Bubble_o  (IDEX_Bubble_o),
      .Freeze_o       (Freeze_o),
      .stall_cnt_o    (stall_cnt_o),
      .flush_cnt_o    (flush_cnt_o),
      .err_timeout_o  (err_timeout_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic add(input logic rst, input logic mr, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                      input logic br, input logic req, input logic ack,
                      input logic [4:0] ctrl, input logic err);
      vec_t v;
      v.rst = rst; v.mr = mr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
      v.u2 = u2; v.br = br; v.req = req; v.ack = ack;
      v.ctrl = ctrl; v.err = err;
      vq.push_back(v);
   endtask

   // monitor: compares one scoreboard entry per cycle on the falling edge
   initial begin
      forever begin
         @(negedge clk_i);
         if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            act_ctrl = {PCWrite_o, IFID_Stall_o, IFID_Flush_o, IDEX_Bubble_o, Freeze_o};
            checks++;
            if (act_ctrl !== mon_e.ctrl) begin
               failures++;
               $display("FAIL ctrl vec=%0d got=%b want=%b", mon_e.idx, act_ctrl, mon_e.ctrl);
            end
            checks++;
            if (stall_cnt_o !== mon_e.stall) begin
               failures++;
               $display("FAIL stall_cnt vec=%0d got=%0d want=%0d", mon_e.idx, stall_cnt_o, mon_e.stall);
            end
            checks++;
            if (flush_cnt_o !== mon_e.flush) begin
               failures++;
               $display("FAIL flush_cnt vec=%0d got=%0d want=%0d", mon_e.idx, flush_cnt_o, mon_e.flush);
            end
            checks++;
            if (err_timeout_o !== mon_e.err) begin
               failures++;
               $display("FAIL err_timeout vec=%0d got=%b want=%b", mon_e.idx, err_timeout_o, mon_e.err);
            end
            checks++;
            if (IFID_Stall_o && IFID_Flush_o) begin
               failures++;
               $display("FAIL stall_flush_excl vec=%0d got=11 want=not both", mon_e.idx);
            end
         end
      end
   end

   // driver: applies vectors #1 after the rising edge and queues expectations
   initial begin
      rst_i = 1'b0;
      IDEX_MemRead_i = 1'b0; IDEX_Rd_i = '0; IFID_Rs1_i = '0; IFID_Rs2_i = '0;
      IFID_UseRs2_i = 1'b0; Branch_taken_i = 1'b0; mem_req_i = 1'b0; mem_ack_i = 1'b0;
      mdl_stall = '0;
      mdl_flush = '0;

      //    rst mr rd rs1 rs2 u2 br req ack ctrl   err
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 0); // reset state, idle
      add(1, 1, 5, 5, 0, 0, 0, 0, 0, C_HZ,   0); // load-use on rs1
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 0);
      add(1, 1, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 0); // rd=x0: no hazard
      add(1, 1, 5, 3, 5, 0, 0, 0, 0, C_IDLE, 0); // rs2 match, rs2 unused
      add(1, 1, 5, 3, 5, 1, 0, 0, 0, C_HZ,   0); // rs2 match, rs2 used
      add(1, 0, 0, 0, 0, 0, 1, 0, 0, C_FL,   0); // taken branch
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 0);
      add(1, 1, 5, 5, 0, 0, 1, 0, 0, C_HZ,   0); // branch + load-use: stall only
      add(1, 0, 0, 0, 0, 0, 1, 0, 0, C_FL,   0); // branch re-evaluated
      add(1, 0, 0, 0, 0, 0, 0, 1, 0, C_MW,   0); // wait cycle 1
      add(1, 0, 0, 0, 0, 0, 1, 1, 0, C_MW,   0); // branch ignored in wait
      add(1, 1, 5, 5, 0, 0, 0, 1, 0, C_MW,   0); // load-use ignored in wait
      add(1, 0, 0, 0, 0, 0, 0, 1, 1, C_IDLE, 0); // ack: freeze drops
      add(1, 0, 0, 0, 0, 0, 0, 1, 1, C_IDLE, 0); // single-cycle access
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 0); // still RUN
      add(1, 0, 0, 0, 0, 0, 0, 1, 0, C_MW,   0); // timeout run, enter wait
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, C_MW,   0); // count 1, req ignored
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, C_MW,   0); // count 2
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, C_MW,   0); // count 3
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, C_MW,   0); // count 4 = MAX_WAIT
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, C_MW,   1); // flag set, still waiting
      add(1, 0, 0, 0, 0, 0, 0, 0, 1, C_IDLE, 1); // ack
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 1); // sticky
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 1);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 0); // reset clears flag and counters
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 0);
      add(1, 0, 0, 0, 0, 0, 0, 1, 0, C_MW,   0); // enter wait
      add(1, 0, 0, 0, 0, 0, 0, 1, 0, C_MW,   0); // count 1
      add(1, 0, 0, 0, 0, 0, 0, 1, 0, C_MW,   0); // count 2
      add(1, 0, 0, 0, 0, 0, 0, 1, 0, C_MW,   0); // count 3
      add(1, 0, 0, 0, 0, 0, 0, 1, 1, C_IDLE, 0); // count 4 with ack
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 1); // flag still set
      add(1, 0, 0, 0, 0, 0, 0, 1, 0, C_MW,   1); // enter wait
      add(1, 0, 0, 0, 0, 0, 0, 1, 0, C_MW,   1);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 0); // reset mid-wait
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 0); // back in RUN
      for (int i = 0; i < 20; i++)
         add(1, 1, 7, 7, 0, 0, 0, 0, 0, C_HZ, 0); // saturate stall counter
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 0);

      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         @(posedge clk_i);
         #1;
         rst_i          = vq[i].rst;
         IDEX_MemRead_i = vq[i].mr;
         IDEX_Rd_i      = vq[i].rd;
         IFID_Rs1_i     = vq[i].rs1;
         IFID_Rs2_i     = vq[i].rs2;
         IFID_UseRs2_i  = vq[i].u2;
         Branch_taken_i = vq[i].br;
         mem_req_i      = vq[i].req;
         mem_ack_i      = vq[i].ack;
         if (!vq[i].rst) begin
            mdl_stall = '0;
            mdl_flush = '0;
         end
         drv_e.idx   = i;
         drv_e.ctrl  = vq[i].ctrl;
         drv_e.stall = mdl_stall;
         drv_e.flush = mdl_flush;
         drv_e.err   = vq[i].err;
         sb.push_back(drv_e);
         if (vq[i].rst) begin
            if (!vq[i].ctrl[4] && (mdl_stall != {CNT_W{1'b1}}))
               mdl_stall = mdl_stall + 1'b1;
            if (vq[i].ctrl[2] && (mdl_flush != {CNT_W{1'b1}}))
               mdl_flush = mdl_flush + 1'b1;
         end
      end

      for (int i = 0; i < 10 && sb.size() > 0; i++)
         @(negedge clk_i);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d want=0", sb.size());
      end
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
